// File: rtl/key_pio_debounced.sv
// key_pio_debounced: Avalon-MM key/switch input port.
// Each input bit passes through a synchroniser chain and a debounce counter
// with a runtime-programmable period. Debounced transitions are captured
// into W1C edge bits according to MODE, and the masked captures raise irq.
//
// Bus handshake: a write is accepted on any clock edge where
// chipselect & ~write_n. readdata is registered from the address mux on
// every edge, independent of chipselect, so a read has exactly one cycle
// of latency.
module key_pio_debounced #(
  parameter int         WIDTH          = 4,
  parameter int         SYNC_STAGES    = 2,
  parameter int         DEBOUNCE_W     = 16,
  parameter int         DEBOUNCE_RESET = 50000,
  parameter logic [1:0] EDGE_RESET     = 2'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RAW     = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_MODE    = 3'd4;
  localparam logic [2:0] ADDR_PERIOD  = 3'd5;

  logic [WIDTH-1:0]      sync_ff [SYNC_STAGES];
  logic [WIDTH-1:0]      sync;
  logic [WIDTH-1:0]      stable;
  logic [DEBOUNCE_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0]      irq_mask;
  logic [WIDTH-1:0]      edge_capture;
  logic [1:0]            mode;
  logic [DEBOUNCE_W-1:0] period;
  logic [DEBOUNCE_W-1:0] p_last;
  logic [WIDTH-1:0]      upd;
  logic [WIDTH-1:0]      cap_set;
  logic [WIDTH-1:0]      cap_clr;
  logic [31:0]           rd_next;
  logic                  wr;
  logic                  wr_mask;
  logic                  wr_capture;
  logic                  wr_mode;
  logic                  wr_period;
  logic                  unused_wdata;

  // Upper writedata bits are not backed by any register in narrow builds.
  assign unused_wdata = ^writedata;

  assign wr         = chipselect & ~write_n;
  assign wr_mask    = wr & (address == ADDR_MASK);
  assign wr_capture = wr & (address == ADDR_CAPTURE);
  assign wr_mode    = wr & (address == ADDR_MODE);
  assign wr_period  = wr & (address == ADDR_PERIOD);

  // A period of 0 is treated as 1, so the terminal count is never below 0.
  assign p_last  = (period == '0) ? '0 : period - 1'b1;
  assign sync    = sync_ff[SYNC_STAGES-1];
  assign cap_clr = wr_capture ? writedata[WIDTH-1:0] : '0;
  assign irq     = |(edge_capture & irq_mask);

  // Synchroniser chain bringing the asynchronous keys into clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= '0;
    end else begin
      sync_ff[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
    end
  end

  // Update events and the capture-set vector selected by the current mode.
  // A period write restarts all counters, so no update fires on that edge.
  always_comb begin
    upd     = '0;
    cap_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = ~wr_period & (sync[i] != stable[i]) & (cnt[i] == p_last);
    end
    case (mode)
      2'd0:    cap_set = upd & sync;
      2'd1:    cap_set = upd & ~sync;
      2'd2:    cap_set = upd;
      default: cap_set = stable;
    endcase
  end

  // Per-bit debounce counters and the debounced state.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable <= (stable & ~upd) | (sync & upd);
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_period || (sync[i] == stable[i]) || upd[i]) cnt[i] <= '0;
        else                                               cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Software-visible control registers and the W1C capture bits; a set on
  // the same edge as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      mode         <= EDGE_RESET;
      period       <= DEBOUNCE_W'(DEBOUNCE_RESET);
    end else begin
      if (wr_mask)   irq_mask <= writedata[WIDTH-1:0];
      if (wr_mode)   mode     <= writedata[1:0];
      if (wr_period) period   <= writedata[DEBOUNCE_W-1:0];
      edge_capture <= (edge_capture & ~cap_clr) | cap_set;
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0]      = stable;
      ADDR_RAW:     rd_next[WIDTH-1:0]      = sync;
      ADDR_MASK:    rd_next[WIDTH-1:0]      = irq_mask;
      ADDR_CAPTURE: rd_next[WIDTH-1:0]      = edge_capture;
      ADDR_MODE:    rd_next[1:0]            = mode;
      ADDR_PERIOD:  rd_next[DEBOUNCE_W-1:0] = period;
      default:      rd_next                 = '0;
    endcase
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

endmodule

// File: tb/tb_key_pio_debounced.sv
// Bench for key_pio_debounced: register table plus multi-cycle debounce,
// capture-mode, W1C and reset sequences. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_key_pio_debounced;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  addr;
    bit          do_wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t rv [17];

  key_pio_debounced #(
    .WIDTH(WIDTH), .SYNC_STAGES(2), .DEBOUNCE_W(16),
    .DEBOUNCE_RESET(50000), .EDGE_RESET(2'd0)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_irq(input string name, input logic exp);
    check(name, {31'b0, irq}, {31'b0, exp});
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    exp_q.push_back(exp);
    tick();
    check(name, readdata, exp_q.pop_front());
    address = 3'd0; chipselect = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic any_irq;

    // reset-state reads, then read/write behaviour of each register
    rv[0]  = '{3'd0, 1'b0, 32'h0,          32'h0};
    rv[1]  = '{3'd1, 1'b0, 32'h0,          32'h0};
    rv[2]  = '{3'd2, 1'b0, 32'h0,          32'h0};
    rv[3]  = '{3'd3, 1'b0, 32'h0,          32'h0};
    rv[4]  = '{3'd4, 1'b0, 32'h0,          32'h0};
    rv[5]  = '{3'd5, 1'b0, 32'h0,          32'd50000};
    rv[6]  = '{3'd6, 1'b0, 32'h0,          32'h0};
    rv[7]  = '{3'd7, 1'b0, 32'h0,          32'h0};
    rv[8]  = '{3'd2, 1'b1, 32'hFFFF_FFFF,  32'hF};
    rv[9]  = '{3'd4, 1'b1, 32'hFFFF_FFFF,  32'h3};
    rv[10] = '{3'd4, 1'b1, 32'h0,          32'h0};
    rv[11] = '{3'd5, 1'b1, 32'hABCD_1234,  32'h1234};
    rv[12] = '{3'd6, 1'b1, 32'hFFFF_FFFF,  32'h0};
    rv[13] = '{3'd7, 1'b1, 32'hFFFF_FFFF,  32'h0};
    rv[14] = '{3'd0, 1'b1, 32'hF,          32'h0};
    rv[15] = '{3'd1, 1'b1, 32'hF,          32'h0};
    rv[16] = '{3'd2, 1'b1, 32'h0,          32'h0};

    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    @(negedge clk);
    wait_cycles(3);
    reset = 1'b0;
    check_irq("reset_irq", 1'b0);

    for (int i = 0; i < 17; i++) begin
      if (rv[i].do_wr) bus_write(rv[i].addr, rv[i].wdata);
      bus_read(rv[i].addr, rv[i].exp, $sformatf("reg_vec_%0d", i));
    end

    // debounce latency: SYNC+P edges
    bus_write(3'd5, 32'd4);
    bus_write(3'd2, 32'h1);
    in_port[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) check_irq("lat_irq_e5", 1'b0);
    end
    check_irq("lat_irq_e6", 1'b1);
    check("lat_data_e6", readdata, 32'h0);
    tick();
    check("lat_data_e7", readdata, 32'h1);
    bus_read(3'd3, 32'h1, "lat_capture");
    bus_read(3'd1, 32'h1, "lat_raw");

    // short glitch rejected, full-length pulse accepted
    bus_write(3'd2, 32'hF);
    bus_write(3'd3, 32'hF);
    in_port[1] = 1'b1;
    wait_cycles(3);
    in_port[1] = 1'b0;
    any_irq = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      any_irq |= irq;
    end
    check("glitch_irq", {31'b0, any_irq}, 32'h0);
    bus_read(3'd3, 32'h0, "glitch_capture");
    bus_read(3'd0, 32'h1, "glitch_data");
    in_port[1] = 1'b1;
    wait_cycles(4);
    in_port[1] = 1'b0;
    wait_cycles(12);
    check_irq("pulse4_irq", 1'b1);
    bus_read(3'd3, 32'h2, "pulse4_capture");
    bus_read(3'd0, 32'h1, "pulse4_data_after");
    bus_write(3'd2, 32'h1);
    check_irq("masked_irq", 1'b0);

    // W1C clear and set-over-clear priority
    in_port[0] = 1'b0; wait_cycles(10);
    in_port[0] = 1'b1; wait_cycles(10);
    bus_read(3'd3, 32'h3, "w1c_before");
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, 32'h2, "w1c_after");
    in_port[0] = 1'b0; wait_cycles(10);
    in_port[0] = 1'b1; wait_cycles(5);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, 32'h3, "w1c_set_wins");
    bus_write(3'd3, 32'h3);
    bus_read(3'd3, 32'h0, "w1c_clear_all");

    // falling-edge mode
    bus_write(3'd4, 32'd1);
    in_port[2] = 1'b1; wait_cycles(10);
    bus_read(3'd3, 32'h0, "m1_press");
    in_port[2] = 1'b0; wait_cycles(10);
    bus_read(3'd3, 32'h4, "m1_release");
    bus_write(3'd3, 32'hF);

    // either-edge mode
    bus_write(3'd4, 32'd2);
    in_port[3] = 1'b1; wait_cycles(10);
    bus_read(3'd3, 32'h8, "m2_press");
    bus_write(3'd3, 32'hF);
    bus_read(3'd3, 32'h0, "m2_cleared");
    in_port[3] = 1'b0; wait_cycles(10);
    bus_read(3'd3, 32'h8, "m2_release");
    bus_write(3'd3, 32'hF);

    // level-high mode: bit0 is held, so it re-sets through a clear
    bus_write(3'd4, 32'd3);
    bus_write(3'd3, 32'hF);
    bus_read(3'd3, 32'h1, "m3_held");
    in_port[0] = 1'b0; wait_cycles(10);
    bus_write(3'd3, 32'hF);
    bus_read(3'd3, 32'h0, "m3_released");
    bus_write(3'd4, 32'd0);

    // reset in the middle of a debounce count
    in_port[0] = 1'b1;
    wait_cycles(4);
    reset = 1'b1; in_port = '0;
    tick();
    reset = 1'b0;
    check_irq("rst_mid_irq", 1'b0);
    bus_read(3'd0, 32'h0, "rst_mid_data");
    bus_read(3'd3, 32'h0, "rst_mid_capture");
    bus_read(3'd5, 32'd50000, "rst_mid_period");
    bus_read(3'd2, 32'h0, "rst_mid_mask");
    bus_read(3'd4, 32'h0, "rst_mid_mode");
    bus_write(3'd5, 32'd4);
    bus_write(3'd2, 32'h1);
    in_port[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) check_irq("rst_lat_irq_e5", 1'b0);
    end
    check_irq("rst_lat_irq_e6", 1'b1);

    // period 0 behaves as period 1
    bus_write(3'd5, 32'd0);
    bus_write(3'd2, 32'h2);
    in_port[1] = 1'b1;
    tick(); tick();
    check_irq("p0_irq_e2", 1'b0);
    tick();
    check_irq("p0_irq_e3", 1'b1);
    bus_read(3'd5, 32'h0, "p0_period");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
